// File: rtl/chunk_build.sv
// Assembles an RGB byte stream into pixels and emits one 3x3 window per interior pixel.
// Chunk element (r,c) is packed at axis_o_data[(3*r+c)*24 +: 24] as {red, grn, blu}.
module chunk_build #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axis_i_vld,
  output logic         axis_i_rdy,
  input  logic [7:0]   axis_i_data,
  output logic         axis_o_vld,
  input  logic         axis_o_rdy,
  output logic [215:0] axis_o_data
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic [1:0] {RED, GRN, BLU} sel_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;

  sel_t          sel;
  logic [7:0]    red_q;
  logic [7:0]    grn_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t        win [3][3];
  pixel_t        lb0 [IMG_W];
  pixel_t        lb1 [IMG_W];

  logic   in_ok;
  logic   pix_ev;
  logic   chunk_ev;
  pixel_t new_pix;

  assign axis_i_rdy = !axis_o_vld || axis_o_rdy;
  assign in_ok      = axis_i_vld && axis_i_rdy;
  assign pix_ev     = in_ok && (sel == BLU);
  assign chunk_ev   = pix_ev && (row >= RW'(2)) && (col >= CW'(2));
  assign new_pix    = '{red: red_q, grn: grn_q, blu: axis_i_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= RED;
      red_q      <= '0;
      grn_q      <= '0;
      col        <= '0;
      row        <= '0;
      axis_o_vld <= 1'b0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      if (in_ok) begin
        case (sel)
          RED: begin red_q <= axis_i_data; sel <= GRN; end
          GRN: begin grn_q <= axis_i_data; sel <= BLU; end
          default: sel <= RED;
        endcase
      end
      if (pix_ev) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb0[col];
        win[1][2] <= lb1[col];
        win[2][2] <= new_pix;
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A new chunk takes priority over acceptance so a same-edge hand-off keeps vld high.
      if (chunk_ev)
        axis_o_vld <= 1'b1;
      else if (axis_o_rdy)
        axis_o_vld <= 1'b0;
    end
  end

  // Line buffers carry no reset: rows 0..1 refill them before any chunk is valid.
  always_ff @(posedge clk) begin
    if (pix_ev) begin
      lb0[col] <= lb1[col];
      lb1[col] <= new_pix;
    end
  end

  always_comb begin
    axis_o_data = '0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        axis_o_data[(3*r+c)*24 +: 24] = win[r][c];
  end

endmodule

// File: tb/tb_chunk_build.sv
// Scoreboard bench for chunk_build: a 4x4 instance and a 5x3 instance share clock and reset.
module tb_chunk_build;

  logic         clk = 1'b0;
  logic         rst;
  logic         ivld  [2];
  logic         irdy  [2];
  logic [7:0]   idata [2];
  logic         ovld  [2];
  logic         ordy  [2];
  logic [215:0] odata [2];

  always #5 clk = ~clk;

  chunk_build #(.IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .rst(rst),
    .axis_i_vld(ivld[0]), .axis_i_rdy(irdy[0]), .axis_i_data(idata[0]),
    .axis_o_vld(ovld[0]), .axis_o_rdy(ordy[0]), .axis_o_data(odata[0])
  );

  chunk_build #(.IMG_W(5), .IMG_H(3)) u_b (
    .clk(clk), .rst(rst),
    .axis_i_vld(ivld[1]), .axis_i_rdy(irdy[1]), .axis_i_data(idata[1]),
    .axis_o_vld(ovld[1]), .axis_o_rdy(ordy[1]), .axis_o_data(odata[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_out [2];
  bit rand_rdy [2];
  bit gaps = 1'b0;
  logic [215:0] q0 [$];
  logic [215:0] q1 [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] pix(input int base, input int r, input int c);
    logic [7:0] rc;
    rc = 8'(16*r + c);
    return {8'(base) + rc, 8'h80 | rc, 8'hFF};
  endfunction

  function automatic logic [215:0] exp_chunk(input int base, input int cr, input int cc);
    logic [215:0] e;
    e = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[(3*i+j)*24 +: 24] = pix(base, cr - 1 + i, cc - 1 + j);
    return e;
  endfunction

  task automatic push_exp(input int d, input logic [215:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_byte(input int d, input logic [7:0] b);
    int budget;
    bit hs;
    budget = 200;
    hs = 1'b0;
    if (gaps) begin
      ivld[d] = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    ivld[d]  = 1'b1;
    idata[d] = b;
    while (!hs) begin
      @(negedge clk);
      hs = irdy[d];
      @(posedge clk); #1;
      budget--;
      if (budget == 0 && !hs) begin
        check("input handshake timeout", 0, 1);
        break;
      end
    end
    ivld[d] = 1'b0;
  endtask

  task automatic send_pixel(input int d, input int base, input int r, input int c, input bit blu = 1'b1);
    logic [23:0] p;
    bit produce;
    p = pix(base, r, c);
    produce = (r >= 2) && (c >= 2);
    send_byte(d, p[23:16]);
    send_byte(d, p[15:8]);
    if (!blu) return;
    if (produce) push_exp(d, exp_chunk(base, r - 1, c - 1));
    send_byte(d, p[7:0]);
    if (produce) check("vld one cycle after blu", ovld[d], 1);
  endtask

  task automatic send_frame(input int d, input int base, input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        send_pixel(d, base, r, c);
  endtask

  task automatic drain(input int d, input int expected);
    int budget;
    budget = 300;
    while (budget > 0 && (ovld[d] || (d == 0 ? q0.size() : q1.size()) != 0)) begin
      @(posedge clk); #1;
      budget--;
    end
    check("chunk count", n_out[d], expected);
    check("scoreboard empty", (d == 0 ? q0.size() : q1.size()), 0);
    n_out[d] = 0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && ovld[d] && ordy[d]) begin
        n_out[d]++;
        if ((d == 0 ? q0.size() : q1.size()) == 0)
          check("unexpected chunk", 1, 0);
        else if (d == 0)
          check("chunk data a", odata[d], q0.pop_front());
        else
          check("chunk data b", odata[d], q1.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      if (rand_rdy[d]) ordy[d] = 1'($urandom_range(0, 1));
  end

  task automatic stall_first(input logic [215:0] exp);
    int budget;
    budget = 300;
    while (!ovld[0] && budget > 0) begin @(posedge clk); #1; budget--; end
    ordy[0] = 1'b0;
    check("first chunk seen", ovld[0], 1);
    check("first [0][0].red", odata[0][23:16], 8'h00);
    check("first [2][2].red", odata[0][8*24+16 +: 8], 8'h22);
    repeat (10) begin
      @(posedge clk); #1;
      check("stall vld", ovld[0], 1);
      check("stall data", odata[0], exp);
      check("stall in rdy", irdy[0], 0);
    end
    ordy[0] = 1'b1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ivld[d] = 1'b0; idata[d] = '0; ordy[d] = 1'b1; rand_rdy[d] = 1'b0; n_out[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset vld a", ovld[0], 0);
    check("reset vld b", ovld[1], 0);
    check("reset in rdy a", irdy[0], 1);
    check("reset data a", odata[0], '0);
    rst = 1'b0;

    // Clean frame, output always ready
    send_frame(0, 8'h00, 4, 4);
    drain(0, 4);

    // First chunk held for 10 cycles
    fork
      send_frame(0, 8'h00, 4, 4);
      stall_first(exp_chunk(8'h00, 1, 1));
    join
    drain(0, 4);

    // Two back-to-back frames
    send_frame(0, 8'h00, 4, 4);
    send_frame(0, 8'h40, 4, 4);
    drain(0, 8);

    // Random input gaps and output backpressure
    gaps = 1'b1;
    rand_rdy[1] = 1'b1;
    send_frame(1, 8'h00, 5, 3);
    send_frame(1, 8'h40, 5, 3);
    rand_rdy[1] = 1'b0; ordy[1] = 1'b1;
    drain(1, 6);
    rand_rdy[0] = 1'b1;
    send_frame(0, 8'h40, 4, 4);
    rand_rdy[0] = 1'b0; ordy[0] = 1'b1;
    drain(0, 4);
    gaps = 1'b0;

    // Reset with a chunk pending: it must be dropped
    ordy[0] = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        send_pixel(0, 8'h00, r, c);
    send_pixel(0, 8'h00, 2, 0);
    send_pixel(0, 8'h00, 2, 1);
    send_pixel(0, 8'h00, 2, 2);
    check("pending before reset", ovld[0], 1);
    pulse_rst();
    check("pending dropped by reset", ovld[0], 0);
    q0.delete();
    ordy[0] = 1'b1;

    // Reset after the green byte of pixel (2,1), then a full clean frame
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        send_pixel(0, 8'h00, r, c);
    send_pixel(0, 8'h00, 2, 0);
    send_pixel(0, 8'h00, 2, 1, 1'b0);
    check("no chunk from partial frame", n_out[0], 0);
    pulse_rst();
    check("vld low after reset", ovld[0], 0);
    send_frame(0, 8'h00, 4, 4);
    drain(0, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
